// File: rtl/arming_sequencer.sv
// Arming/failsafe sequencer: decides when the motors may spin and clamps all four motor
// commands to a shared ceiling that ramps up on arming and down on receiver loss.
module arming_sequencer #(
    parameter int unsigned SW_THRESH = 128,
    parameter int unsigned THR_LOW   = 16,
    parameter int unsigned ARM_HOLD  = 50000,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  throttle,
    input  logic [7:0]  switch_val,
    input  logic        rx_strobe,
    input  logic [10:0] m1_in,
    input  logic [10:0] m2_in,
    input  logic [10:0] m3_in,
    input  logic [10:0] m4_in,
    output logic [10:0] m1_out,
    output logic [10:0] m2_out,
    output logic [10:0] m3_out,
    output logic [10:0] m4_out,
    output logic        armed,
    output logic        failsafe,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StArmWait  = 3'd1,
        StSpinup   = 3'd2,
        StArmed    = 3'd3,
        StFailsafe = 3'd4
    } state_e;

    localparam int unsigned WdW   = $clog2(TIMEOUT + 1);
    localparam int unsigned HoldW = $clog2(ARM_HOLD + 1);
    localparam int unsigned DivW  = $clog2(RAMP_DIV + 1);

    localparam logic [WdW-1:0]   WdMax    = WdW'(TIMEOUT);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ARM_HOLD - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(RAMP_DIV - 1);
    localparam logic [7:0]       SwThr    = 8'(SW_THRESH);
    localparam logic [7:0]       ThrLow   = 8'(THR_LOW);
    localparam logic [11:0]      Step12   = 12'(RAMP_STEP);
    localparam logic [10:0]      CeilMax  = 11'd2047;

    state_e             state_q, state_d;
    logic [10:0]        ceil_q, ceil_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [DivW-1:0]    div_q, div_d;
    logic [WdW-1:0]     wd_q, wd_d;
    logic               low_seen_q, low_seen_d;
    logic [10:0]        m1_q, m2_q, m3_q, m4_q;
    logic [10:0]        m1_d, m2_d, m3_d, m4_d;

    logic               switch_low;
    logic               throttle_high;
    logic               rx_lost;
    logic               div_wrap;
    logic [DivW-1:0]    div_inc;
    logic [11:0]        ceil_sum;
    logic [10:0]        ceil_up;
    logic [10:0]        ceil_dn;
    logic               gate_en;

    function automatic logic [10:0] gate(input logic [10:0] cmd, input logic [10:0] lim,
                                         input logic en);
        if (!en) begin
            return 11'd0;
        end
        return (cmd < lim) ? cmd : lim;
    endfunction

    assign switch_low    = switch_val < SwThr;
    assign throttle_high = throttle > ThrLow;
    assign rx_lost       = wd_q == WdMax;

    assign div_wrap = div_q == DivLast;
    assign div_inc  = div_wrap ? '0 : div_q + 1'b1;
    // Step is computed one bit wider so the climb to full scale saturates instead of wrapping.
    assign ceil_sum = {1'b0, ceil_q} + Step12;
    assign ceil_up  = (ceil_sum > {1'b0, CeilMax}) ? CeilMax : ceil_sum[10:0];
    assign ceil_dn  = ({1'b0, ceil_q} <= Step12) ? 11'd0 : ceil_q - Step12[10:0];

    // Receiver watchdog runs regardless of state.
    always_comb begin
        wd_d = wd_q;
        if (rx_strobe) begin
            wd_d = '0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ceil_d     = ceil_q;
        hold_d     = hold_q;
        div_d      = div_q;
        low_seen_d = low_seen_q | switch_low;

        if (switch_low) begin
            state_d = StDisarmed;
            ceil_d  = 11'd0;
        end else begin
            unique case (state_q)
                StDisarmed: begin
                    if (!throttle_high && !rx_lost && low_seen_q) begin
                        state_d = StArmWait;
                        hold_d  = '0;
                    end
                end
                StArmWait: begin
                    if (throttle_high || rx_lost) begin
                        state_d = StDisarmed;
                    end else if (hold_q == HoldLast) begin
                        state_d = StSpinup;
                        ceil_d  = 11'd0;
                        div_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                StSpinup: begin
                    if (rx_lost) begin
                        state_d = StFailsafe;
                        div_d   = '0;
                    end else begin
                        div_d = div_inc;
                        if (div_wrap) begin
                            ceil_d = ceil_up;
                            if (ceil_up == CeilMax) begin
                                state_d = StArmed;
                            end
                        end
                    end
                end
                StArmed: begin
                    ceil_d = CeilMax;
                    if (rx_lost) begin
                        state_d = StFailsafe;
                        div_d   = '0;
                    end
                end
                StFailsafe: begin
                    // Only ramp completion (or a kill) leaves failsafe; a recovered link does not.
                    if (ceil_q == 11'd0) begin
                        state_d    = StDisarmed;
                        low_seen_d = 1'b0;
                    end else begin
                        div_d = div_inc;
                        if (div_wrap) begin
                            ceil_d = ceil_dn;
                        end
                    end
                end
                default: begin
                    state_d = StDisarmed;
                    ceil_d  = 11'd0;
                end
            endcase
        end
    end

    // Gating uses the ceiling as it stood this cycle, before any ramp update.
    always_comb begin
        gate_en = (state_q == StSpinup) || (state_q == StArmed) || (state_q == StFailsafe);
        m1_d    = gate(m1_in, ceil_q, gate_en);
        m2_d    = gate(m2_in, ceil_q, gate_en);
        m3_d    = gate(m3_in, ceil_q, gate_en);
        m4_d    = gate(m4_in, ceil_q, gate_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StDisarmed;
            ceil_q     <= 11'd0;
            hold_q     <= '0;
            div_q      <= '0;
            wd_q       <= WdMax;
            low_seen_q <= 1'b0;
            m1_q       <= 11'd0;
            m2_q       <= 11'd0;
            m3_q       <= 11'd0;
            m4_q       <= 11'd0;
        end else begin
            state_q    <= state_d;
            ceil_q     <= ceil_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            wd_q       <= wd_d;
            low_seen_q <= low_seen_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            m3_q       <= m3_d;
            m4_q       <= m4_d;
        end
    end

    assign m1_out   = m1_q;
    assign m2_out   = m2_q;
    assign m3_out   = m3_q;
    assign m4_out   = m4_q;
    assign state    = state_q;
    assign armed    = state_q == StArmed;
    assign failsafe = state_q == StFailsafe;

endmodule

// File: tb/tb_arming_sequencer.sv
// Bench for arming_sequencer: directed vector table for the arming/failsafe scenarios plus
// randomized traffic, all checked every cycle against a phase-timer reference model.
module tb_arming_sequencer;

    localparam int unsigned SW_THRESH = 128;
    localparam int unsigned THR_LOW   = 16;
    localparam int unsigned ARM_HOLD  = 8;
    localparam int unsigned RAMP_DIV  = 4;
    localparam int unsigned RAMP_STEP = 256;
    localparam int unsigned TIMEOUT   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  throttle;
    logic [7:0]  switch_val;
    logic        rx_strobe;
    logic [10:0] m1_in, m2_in, m3_in, m4_in;
    logic [10:0] m1_out, m2_out, m3_out, m4_out;
    logic        armed;
    logic        failsafe;
    logic [2:0]  state;

    arming_sequencer #(
        .SW_THRESH (SW_THRESH),
        .THR_LOW   (THR_LOW),
        .ARM_HOLD  (ARM_HOLD),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .throttle   (throttle),
        .switch_val (switch_val),
        .rx_strobe  (rx_strobe),
        .m1_in      (m1_in),
        .m2_in      (m2_in),
        .m3_in      (m3_in),
        .m4_in      (m4_in),
        .m1_out     (m1_out),
        .m2_out     (m2_out),
        .m3_out     (m3_out),
        .m4_out     (m4_out),
        .armed      (armed),
        .failsafe   (failsafe),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int strobe_mode = 1;  // 0: none, 1: every 5th cycle, 2: random

    // Reference model: state id, cycles spent in the current state, ceiling at state entry,
    // cycles since the last strobe, and the "switch was low" latch.
    int ms = 0, mt = 0, mc0 = 0, msince = TIMEOUT;
    bit mlow = 1'b0;
    int mout[4] = '{0, 0, 0, 0};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int spin_ceil(input int t);
        return imin((t / RAMP_DIV) * RAMP_STEP, 2047);
    endfunction

    function automatic int model_ceil();
        case (ms)
            2: return spin_ceil(mt);
            3: return 2047;
            4: return imax(mc0 - (mt / RAMP_DIV) * RAMP_STEP, 0);
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int  c;
        int  ins[4];
        bit  lost;
        if (rst) begin
            ms = 0; mt = 0; mc0 = 0; msince = TIMEOUT; mlow = 1'b0;
            for (int i = 0; i < 4; i++) mout[i] = 0;
            return;
        end
        ins  = '{int'(m1_in), int'(m2_in), int'(m3_in), int'(m4_in)};
        lost = (msince >= TIMEOUT);
        c    = model_ceil();
        for (int i = 0; i < 4; i++) mout[i] = (ms >= 2) ? imin(ins[i], c) : 0;
        if (int'(switch_val) < SW_THRESH) begin
            ms = 0; mt = 0; mlow = 1'b1;
        end else begin
            case (ms)
                0: if (int'(throttle) <= THR_LOW && !lost && mlow) begin ms = 1; mt = 0; end
                1: begin
                    if (int'(throttle) > THR_LOW || lost) ms = 0;
                    else if (mt == ARM_HOLD - 1) begin ms = 2; mt = 0; end
                    else mt++;
                end
                2: begin
                    if (lost) begin ms = 4; mc0 = c; mt = 0; end
                    else begin
                        mt++;
                        if (spin_ceil(mt) >= 2047) ms = 3;
                    end
                end
                3: if (lost) begin ms = 4; mc0 = 2047; mt = 0; end
                4: begin
                    if (c == 0) begin ms = 0; mlow = 1'b0; end
                    else mt++;
                end
                default: ms = 0;
            endcase
        end
        msince = rx_strobe ? 0 : imin(msince + 1, TIMEOUT);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic tick();
        case (strobe_mode)
            0:       rx_strobe = 1'b0;
            1:       rx_strobe = (cyc % 5 == 0);
            default: rx_strobe = ($urandom_range(0, 3) == 0);
        endcase
        @(posedge clk);
        model_edge();
        #1;
        check("state", int'(state), ms);
        check("armed", int'(armed), int'(ms == 3));
        check("failsafe", int'(failsafe), int'(ms == 4));
        check("m1_out", int'(m1_out), mout[0]);
        check("m2_out", int'(m2_out), mout[1]);
        check("m3_out", int'(m3_out), mout[2]);
        check("m4_out", int'(m4_out), mout[3]);
        cyc++;
    endtask

    typedef struct {
        bit rst;
        int thr;
        int sw;
        int smode;
        int m1;
        int mo;
        int n;
        int st;
        int e1;
        int e2;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int mode;
        rst = 1'b1; throttle = 8'd0; switch_val = 8'd200; rx_strobe = 1'b0;
        m1_in = 11'd1500; m2_in = 11'd2047; m3_in = 11'd2047; m4_in = 11'd2047;

        //                rst thr  sw  sm    m1    mo    n  st    e1    e2
        vecs.push_back('{1,   0, 200, 1, 1500, 2047,  2, 0,    0,    0});  // reset, switch high
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 30, 0,    0,    0});  // no low seen: stay
        vecs.push_back('{0,   0,   0, 1, 1500, 2047,  1, 0,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 1,    0,    0});  // arm wait
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  7, 1,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 2,    0,    0});  // 8 cycles -> spinup
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  5, 2,  256,  256});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  4, 2,  512,  512});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 16, 2, 1500, 1536});  // m1 saturates
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  7, 3, 1500, 1792});  // armed
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 3, 1500, 2047});
        vecs.push_back('{0,   0, 200, 0, 1500, 2047, 16, 3, 1500, 2047});  // strobes stop
        vecs.push_back('{0,   0, 200, 0, 1500, 2047,  1, 4, 1500, 2047});  // failsafe
        vecs.push_back('{0,   0, 200, 0, 1500, 2047,  5, 4, 1500, 1791});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 12, 4, 1023, 1023});  // strobes resume
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 15, 4,  255,  255});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 0,    0,    0});  // ramp done
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 10, 0,    0,    0});  // re-arm blocked
        vecs.push_back('{0,   0,   0, 1, 1500, 2047,  1, 0,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 1,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  5, 1,    0,    0});  // hold_cnt = 5
        vecs.push_back('{0,  40, 200, 1, 1500, 2047,  1, 0,    0,    0});  // throttle abort
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 1,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  7, 1,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 1500, 2047,  1, 2,    0,    0});  // fresh 8 cycles
        vecs.push_back('{0,   0, 200, 1, 1500, 2047, 12, 2,  512,  512});  // ceil now 768
        vecs.push_back('{0,   0,  50, 1, 1500, 2047,  1, 0,  768,  768});  // kill mid-spinup
        vecs.push_back('{0,   0,  50, 1, 1500, 2047,  1, 0,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 2047, 2047,  1, 1,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 2047, 2047,  8, 2,    0,    0});
        vecs.push_back('{0,   0, 200, 1, 2047, 2047, 33, 3, 2047, 2047});
        vecs.push_back('{1,   0, 200, 1, 2047, 2047,  1, 0,    0,    0});  // reset while armed
        vecs.push_back('{0,   0,   0, 0, 2047, 2047,  1, 0,    0,    0});
        vecs.push_back('{0,   0, 200, 0, 2047, 2047,  5, 0,    0,    0});  // lost until strobe
        vecs.push_back('{0,   0, 200, 1, 2047, 2047,  2, 1,    0,    0});

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            throttle    = 8'(vecs[i].thr);
            switch_val  = 8'(vecs[i].sw);
            strobe_mode = vecs[i].smode;
            m1_in       = 11'(vecs[i].m1);
            m2_in       = 11'(vecs[i].mo);
            m3_in       = 11'(vecs[i].mo);
            m4_in       = 11'(vecs[i].mo);
            repeat (vecs[i].n) tick();
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d_m1", i), int'(m1_out), vecs[i].e1);
            check($sformatf("vec%0d_m2", i), int'(m2_out), vecs[i].e2);
        end

        // Randomized traffic in 50-cycle regimes: calm, link loss, noisy boundaries, kill pulses.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) mode = $urandom_range(0, 3);
            rst = ($urandom_range(0, 999) == 0);
            case (mode)
                0, 1: begin
                    switch_val  = 8'($urandom_range(128, 255));
                    throttle    = 8'($urandom_range(0, 16));
                    strobe_mode = (mode == 0) ? 1 : 0;
                end
                2: begin
                    case ($urandom_range(0, 4))
                        0: switch_val = 8'd0;
                        1: switch_val = 8'd127;
                        2: switch_val = 8'd128;
                        3: switch_val = 8'd255;
                        default: switch_val = 8'($urandom_range(0, 255));
                    endcase
                    case ($urandom_range(0, 3))
                        0: throttle = 8'd16;
                        1: throttle = 8'd17;
                        default: throttle = 8'($urandom_range(0, 20));
                    endcase
                    strobe_mode = 2;
                end
                default: begin
                    switch_val  = (i % 50 < 2) ? 8'd0 : 8'd200;
                    throttle    = 8'd0;
                    strobe_mode = 1;
                end
            endcase
            m1_in = 11'($urandom_range(0, 2047));
            m2_in = 11'($urandom_range(0, 2047));
            m3_in = 11'($urandom_range(0, 2047));
            m4_in = 11'($urandom_range(0, 2047));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arming_sequencer.md
Name: arming_sequencer

Overview:
- Safety sequencer between the four motor_offset_summer outputs and the four pwm_generator inputs.
- Decides when the motors may spin, based on the decoded throttle and switch receiver values and on receiver liveness.
- Gates all four motor commands with a shared ceiling. The ceiling ramps up on arming and ramps down on receiver loss (failsafe).
- Drives armed/failsafe status for the LED logic.

Parameters:
- SW_THRESH, 128: switch_val >= SW_THRESH means switch high (arm request); below means switch low (kill).
- THR_LOW, 16: throttle <= THR_LOW counts as stick-low.
- ARM_HOLD, 50000: cycles that switch-high and stick-low must hold in ARM_WAIT before spin-up.
- RAMP_DIV, 1000: cycles between ceiling steps in SPINUP and FAILSAFE.
- RAMP_STEP, 8: ceiling increment/decrement per step (11-bit).
- TIMEOUT, 100000: cycles without rx_strobe before the receiver is declared lost.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- throttle  in  8  decoded throttle value.
- switch_val  in  8  decoded switch-channel value.
- rx_strobe  in  1  one-cycle pulse on any receiver-channel update.
- m1_in, m2_in, m3_in, m4_in  in  11 each  summed motor commands.
- m1_out, m2_out, m3_out, m4_out  out  11 each  gated commands to the PWM generators.
- armed  out  1  high while in ARMED.
- failsafe  out  1  high while in FAILSAFE.
- state  out  3  current state encoding, for LEDs and debug.

Behaviour:
- States and encoding: DISARMED=0, ARM_WAIT=1, SPINUP=2, ARMED=3, FAILSAFE=4. Encodings 5–7 are illegal and go to DISARMED.
- Reset (rst high at a clk edge):
  - state=DISARMED, ceil=0, all mN_out=0, armed=0, failsafe=0.
  - hold_cnt=0, div_cnt=0, low_seen=0.
  - wd_cnt=TIMEOUT, so rx_lost is true until the first strobe.
- Watchdog:
  - rx_strobe sets wd_cnt=0.
  - Otherwise wd_cnt increments, saturating at TIMEOUT.
  - rx_lost = (wd_cnt==TIMEOUT). It runs in every state.
- low_seen:
  - Set on any cycle with switch low.
  - Cleared by reset and on the FAILSAFE→DISARMED exit.
  - After reset, or after a completed failsafe, the pilot must cycle the switch low before arming again.
- Transition priority each cycle: switch low > rx_lost > state-local rules.
- Switch low, any state: next state DISARMED, ceil=0. This is an immediate kill, including mid-SPINUP and mid-FAILSAFE.
- DISARMED → ARM_WAIT when all of the following hold: switch high, throttle<=THR_LOW, !rx_lost, low_seen. hold_cnt=0 on entry.
- ARM_WAIT:
  - hold_cnt increments each cycle.
  - throttle>THR_LOW or rx_lost → DISARMED.
  - hold_cnt==ARM_HOLD-1 → SPINUP, with ceil=0 and div_cnt=0.
- SPINUP:
  - div_cnt counts 0..RAMP_DIV-1 and wraps.
  - On wrap, ceil = min(ceil+RAMP_STEP, 2047). Compute at 12 bits, then saturate.
  - Go to ARMED on the cycle ceil reaches 2047.
  - rx_lost → FAILSAFE, with ceil keeping its current value.
- ARMED:
  - ceil stays 2047.
  - rx_lost → FAILSAFE with div_cnt=0.
- FAILSAFE:
  - On div_cnt wrap, ceil = max(ceil-RAMP_STEP, 0), saturating (no underflow).
  - When ceil==0 → DISARMED and low_seen cleared.
  - Receiver recovery does NOT exit FAILSAFE; only the ramp completing or switch low exits.
- Output gating, registered with 1-cycle latency:
  - In SPINUP, ARMED, FAILSAFE: mN_out = min(mN_in, ceil), using the ceil value before the update.
  - In DISARMED, ARM_WAIT: mN_out = 0.
- Status outputs:
  - armed and failsafe are decoded from the registered state.
  - state equals the state register.
- Simultaneous events:
  - rx_strobe in the same cycle wd_cnt would reach TIMEOUT clears it, and rx_lost stays 0.
  - Switch low together with rx_lost gives DISARMED, not FAILSAFE.

Test Plan (bench overrides: ARM_HOLD=8, RAMP_DIV=4, RAMP_STEP=256, TIMEOUT=20; rx_strobe every 5 cycles unless stated):
- Reset with switch_val=200 already high, throttle=0 → stays DISARMED indefinitely and all mN_out=0. Drop switch to 0 for 1 cycle, then raise to 200 → ARM_WAIT next cycle.
- Arm sequence, m1_in=1500 and others 2047:
  - ARM_WAIT lasts 8 cycles, then SPINUP.
  - ceil steps 256, 512, … every 4 cycles, and m2_out tracks ceil.
  - m1_out saturates at 1500 once ceil=1536.
  - ARMED (armed=1) after the 8th step, ceil=2047.
- In ARM_WAIT at hold_cnt=5, throttle=40 → DISARMED next cycle, outputs 0. Re-arm requires a full 8 fresh cycles.
- ARMED, then stop rx_strobe:
  - 20 cycles after the last strobe, FAILSAFE (failsafe=1).
  - ceil drops 2047→1791→…→0 every 4 cycles, then DISARMED.
  - Resuming strobes mid-ramp does not stop the ramp.
  - Re-arm blocked until switch goes low.
- Mid-SPINUP with ceil=768, switch_val=50 → next cycle DISARMED, ceil=0, mN_out=0 one cycle later.
- Assert rst during ARMED with m1_in=2047 → next cycle state=0, all outputs 0, rx_lost=1 until the next strobe.
